// File: rtl/isdu.sv
// Instruction sequencing and decode unit: a Moore FSM that steps the datapath
// through fetch, decode and execute of a small LC-3 style instruction subset.
module isdu (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       MARMUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    HALTED    = 5'd0,
    S18       = 5'd1,
    S33_1     = 5'd2,
    S33_2     = 5'd3,
    S33_3     = 5'd4,
    S35       = 5'd5,
    S32       = 5'd6,
    S01       = 5'd7,
    S05       = 5'd8,
    S09       = 5'd9,
    S00       = 5'd10,
    S22       = 5'd11,
    S12       = 5'd12,
    S04       = 5'd13,
    S21       = 5'd14,
    S06       = 5'd15,
    S25_1     = 5'd16,
    S25_2     = 5'd17,
    S25_3     = 5'd18,
    S27       = 5'd19,
    S07       = 5'd20,
    S23       = 5'd21,
    S16_1     = 5'd22,
    S16_2     = 5'd23,
    S16_3     = 5'd24,
    PAUSE_IR1 = 5'd25,
    PAUSE_IR2 = 5'd26
  } state_t;

  state_t state, state_next;

  assign state_dbg = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= HALTED;
    else       state <= state_next;
  end

  // Run and Continue are plain levels, not handshakes: Run is only looked at
  // in HALTED, Continue only in the two pause states.
  always_comb begin
    state_next = state;
    unique case (state)
      HALTED:    if (Run) state_next = S18;
      S18:       state_next = S33_1;
      S33_1:     state_next = S33_2;
      S33_2:     state_next = S33_3;
      S33_3:     state_next = S35;
      S35:       state_next = S32;
      S32: begin
        unique case (Opcode)
          4'b0001: state_next = S01;
          4'b0101: state_next = S05;
          4'b1001: state_next = S09;
          4'b0000: state_next = S00;
          4'b1100: state_next = S12;
          4'b0100: state_next = S04;
          4'b0110: state_next = S06;
          4'b0111: state_next = S07;
          4'b1101: state_next = PAUSE_IR1;
          default: state_next = S18;
        endcase
      end
      S01, S05, S09, S22, S12, S21, S27: state_next = S18;
      S00:       state_next = BEN ? S22 : S18;
      S04:       state_next = S21;
      S06:       state_next = S25_1;
      S25_1:     state_next = S25_2;
      S25_2:     state_next = S25_3;
      S25_3:     state_next = S27;
      S07:       state_next = S23;
      S23:       state_next = S16_1;
      S16_1:     state_next = S16_2;
      S16_2:     state_next = S16_3;
      S16_3:     state_next = S18;
      PAUSE_IR1: if (Continue)  state_next = PAUSE_IR2;
      PAUSE_IR2: if (!Continue) state_next = S18;
      default:   state_next = HALTED;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    MARMUX     = 1'b0;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state)
      S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S33_1, S33_2, S25_1, S25_2: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
      end
      S33_3, S25_3: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        LD_MDR = 1'b1;
      end
      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      // IR_5 high means the immediate form, which is the SR2MUX=0 input.
      S01, S05: begin
        SR1MUX  = 1'b1;
        SR2MUX  = ~IR_5;
        ALUK    = (state == S05) ? 2'b01 : 2'b00;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S09: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b10;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S22: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S12: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S04: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S21: begin
        ADDR2MUX = 2'b11;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S06, S07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S23: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S16_1, S16_2, S16_3: Mem_WE = 1'b1;
      PAUSE_IR1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/isdu.md
ISDU -- requirements
Module: isdu

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high; forces state Halted immediately.
REQ-003 Run  input  1  level; starts execution from Halted.
REQ-004 Continue  input  1  level; releases PAUSE states.
REQ-005 Opcode  input  4  IR[15:12] from datapath.
REQ-006 IR_5  input  1  IR[5]; 1 = immediate form of ADD/AND.
REQ-007 BEN  input  1  branch-enable flag from datapath.
REQ-008 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register load strobes to datapath.
REQ-009 GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle.
REQ-010 PCMUX  output  2  00 = PC+1, 01 = bus, 10 = address adder.
REQ-011 ADDR2MUX  output  2  00 = 0, 01 = sext(IR[5:0]), 10 = sext(IR[8:0]), 11 = sext(IR[10:0]).
REQ-012 ALUK  output  2  00 ADD, 01 AND, 10 NOT A, 11 PASS A.
REQ-013 SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MARMUX  output  1 each  0 selects: sext(IR[4:0]) / PC / IR[11:9] / IR[11:9] / adder; 1 selects: SR2 / SR1 / R7 / IR[8:6] / unused.
REQ-014 MIO_EN  output  1  MDR loads from memory data when 1, from bus when 0.
REQ-015 Mem_OE, Mem_WE  output  1 each  active-high memory read / write enables.

Function
REQ-016 Outputs SHALL be Moore: decoded combinationally from current state only; every output not listed for a state SHALL be 0.
REQ-017 States: Halted, S18, S33_1, S33_2, S33_3, S35, S32, S01, S05, S09, S00, S22, S12, S04, S21, S06, S25_1, S25_2, S25_3, S27, S07, S23, S16_1, S16_2, S16_3, PauseIR1, PauseIR2.
REQ-018 Halted: all outputs 0; -> S18 when Run=1, else stay.
REQ-019 Fetch: S18 (GatePC, LD_MAR, LD_PC, PCMUX=00) -> S33_1 -> S33_2 -> S33_3, each with Mem_OE=1, MIO_EN=1; S33_3 also LD_MDR -> S35 (GateMDR, LD_IR) -> S32 (LD_BEN).
REQ-020 Memory read latency SHALL be exactly 3 cycles from MAR load; no wait-state input.
REQ-021 S32 decode: 0001->S01, 0101->S05, 1001->S09, 0000->S00, 1100->S12, 0100->S04, 0110->S06, 0111->S07, 1101->PauseIR1; any other opcode -> S18 (no-op).
REQ-022 S01/S05: SR1MUX=1, SR2MUX=IR_5 inverted (IR_5=1 selects imm5), ALUK=00/01, GateALU, LD_REG, LD_CC, DRMUX=0 -> S18.
REQ-023 S09: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC, DRMUX=0 -> S18.
REQ-024 S00: -> S22 if BEN=1 else S18; S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
REQ-025 S12: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, LD_PC -> S18.
REQ-026 S04: GatePC, DRMUX=1, LD_REG -> S21; S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC -> S18.
REQ-027 S06/S07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR; S06 -> S25_1, S07 -> S23.
REQ-028 S25_1..S25_3: Mem_OE, MIO_EN; S25_3 LD_MDR -> S27: GateMDR, DRMUX=0, LD_REG, LD_CC -> S18.
REQ-029 S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR -> S16_1; S16_1..S16_3: Mem_WE -> S18 after S16_3.
REQ-030 PauseIR1: LD_LED; stay while Continue=0, -> PauseIR2 when 1; PauseIR2: stay while Continue=1, -> S18 when 0.
REQ-031 Run dropping to 0 outside Halted SHALL NOT affect sequencing.

Reset
REQ-032 Reset=1 SHALL asynchronously force Halted in any state, including mid-memory-access; all outputs 0 while asserted and in the first cycle after release.
REQ-033 Reset release with Run=1 SHALL enter S18 on the first subsequent rising edge.

Verification
REQ-034 Reset, Run=1, Opcode=0001, IR_5=1 -> S18,S33_1..3,S35,S32,S01,S18; in S01 LD_REG=LD_CC=GateALU=1, SR2MUX=0, ALUK=00.
REQ-035 Opcode=0000, BEN=0 -> S32,S00,S18 with LD_PC=0 in S00; BEN=1 -> S22 with PCMUX=10, ADDR2MUX=10, LD_PC=1.
REQ-036 Opcode=0111 -> S07 (LD_MAR, ADDR2MUX=01), S23 (LD_MDR, MIO_EN=0), Mem_WE=1 exactly 3 cycles, then S18.
REQ-037 Opcode=1101 -> PauseIR1 held 10 cycles with Continue=0 (LD_LED=1); Continue=1 -> PauseIR2 held; Continue=0 -> S18.
REQ-038 Reset pulsed during S25_2 -> Mem_OE and all strobes drop to 0 immediately without a clock edge; state Halted.
REQ-039 Opcode=1111 -> S32 then S18 with no LD_REG/LD_PC/Mem_WE asserted; gate outputs one-hot-or-zero in every cycle of all runs.
